// File: rtl/ad2s1210_multi_reader.sv
// ad2s1210_multi_reader: pulses a shared SAMPLE line, then reads N AD2S1210 resolvers in turn
// over one SPI master, emitting one tagged result beat per channel per pass.
//
// state   | meaning
// IDLE    | waiting for start
// SAMPLE  | SAMPLE pin held low
// SETTLE  | settle delay after SAMPLE rises
// REQUEST | SPI transfer offered for the current channel
// WAIT    | waiting for the SPI completion strobe
// OUTPUT  | result beat offered on data_out
// SWITCH  | settle delay after the position->velocity mode change
module ad2s1210_multi_reader #(
    parameter int N_CHANNELS    = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               read_mode,
    input  logic [7:0]               sample_length,
    input  logic [7:0]               sample_delay,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    input  logic [31:0]              spi_data_in,
    input  logic                     spi_data_valid,
    output logic                     spi_transfer_valid,
    input  logic                     spi_transfer_ready,
    output logic [31:0]              spi_transfer_data,
    output logic [2:0]               spi_transfer_dest,
    output logic [1:0]               mode,
    output logic                     sample,
    output logic                     busy,
    output logic [N_CHANNELS-1:0]    fault_flags,
    output logic                     timeout_error,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic [31:0]              data_out_data,
    output logic [3:0]               data_out_dest,
    output logic [7:0]               data_out_user,
    output logic                     data_out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_SETTLE, S_REQUEST, S_WAIT, S_OUTPUT, S_SWITCH
    } state_t;

    localparam logic [2:0] LAST_CH = 3'(N_CHANNELS - 1);

    state_t                   state, state_next;
    logic [2:0]               channel;
    logic [7:0]               delay_cnt;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic                     both_passes;
    logic                     vel_pass;
    logic                     last_channel;
    logic                     spi_fire;
    logic                     out_fire;
    logic                     wait_expired;
    logic [DATA_WIDTH-1:0]    raw;
    logic [31:0]              result;
    logic                     unused_payload_lsbs;

    assign vel_pass          = mode[1];
    assign last_channel      = (channel == LAST_CH);
    assign spi_fire          = spi_transfer_valid && spi_transfer_ready;
    assign out_fire          = data_out_valid && data_out_ready;
    assign wait_expired      = (timeout != '0) && (wait_cnt == timeout - TIMEOUT_WIDTH'(1));
    assign spi_transfer_data = 32'h0;
    assign spi_transfer_dest = channel;

    // payload bits below the configured resolution are discarded
    assign raw                 = spi_data_in[31 -: DATA_WIDTH];
    assign unused_payload_lsbs = ^spi_data_in[31-DATA_WIDTH:8];
    assign result = vel_pass ? {{(32-DATA_WIDTH){raw[DATA_WIDTH-1]}}, raw}
                             : {{(32-DATA_WIDTH){1'b0}}, raw};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_SAMPLE;
            S_SAMPLE:  if (delay_cnt == 8'd0) state_next = S_SETTLE;
            S_SETTLE:  if (delay_cnt == 8'd0) state_next = S_REQUEST;
            S_REQUEST: if (spi_fire) state_next = S_WAIT;
            S_WAIT: begin
                if (spi_data_valid)    state_next = S_OUTPUT;
                else if (wait_expired) state_next = S_IDLE;
            end
            S_OUTPUT: begin
                if (out_fire) begin
                    if (!last_channel)                 state_next = S_REQUEST;
                    else if (both_passes && !vel_pass) state_next = S_SWITCH;
                    else                               state_next = S_IDLE;
                end
            end
            S_SWITCH:  if (delay_cnt == 8'd0) state_next = S_REQUEST;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            channel            <= 3'd0;
            delay_cnt          <= 8'd0;
            wait_cnt           <= '0;
            both_passes        <= 1'b0;
            mode               <= 2'b00;
            sample             <= 1'b1;
            busy               <= 1'b0;
            fault_flags        <= '0;
            timeout_error      <= 1'b0;
            spi_transfer_valid <= 1'b0;
            data_out_valid     <= 1'b0;
            data_out_data      <= 32'h0;
            data_out_dest      <= 4'h0;
            data_out_user      <= 8'h0;
            data_out_last      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        both_passes <= (read_mode == 2'd2);
                        mode        <= (read_mode == 2'd1) ? 2'b10 : 2'b00;
                        fault_flags <= '0;
                        channel     <= 3'd0;
                        busy        <= 1'b1;
                        sample      <= 1'b0;
                        delay_cnt   <= (sample_length == 8'd0) ? 8'd0 : sample_length - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (delay_cnt == 8'd0) begin
                        sample    <= 1'b1;
                        delay_cnt <= sample_delay;
                    end else begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                S_SETTLE, S_SWITCH: begin
                    if (delay_cnt == 8'd0) spi_transfer_valid <= 1'b1;
                    else                   delay_cnt <= delay_cnt - 8'd1;
                end
                S_REQUEST: begin
                    if (spi_fire) begin
                        spi_transfer_valid <= 1'b0;
                        wait_cnt           <= '0;
                    end
                end
                S_WAIT: begin
                    if (spi_data_valid) begin
                        data_out_valid <= 1'b1;
                        data_out_data  <= result;
                        data_out_dest  <= {channel, vel_pass};
                        data_out_user  <= spi_data_in[7:0];
                        data_out_last  <= last_channel && (!both_passes || vel_pass);
                        for (int i = 0; i < N_CHANNELS; i++) begin
                            if (channel == 3'(i) && spi_data_in[7:0] != 8'h00)
                                fault_flags[i] <= 1'b1;
                        end
                    end else if (wait_expired) begin
                        timeout_error <= 1'b1;
                        sample        <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_fire) begin
                        data_out_valid <= 1'b0;
                        if (!last_channel) begin
                            channel            <= channel + 3'd1;
                            spi_transfer_valid <= 1'b1;
                        end else if (both_passes && !vel_pass) begin
                            mode      <= 2'b10;
                            channel   <= 3'd0;
                            delay_cnt <= sample_delay;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ad2s1210_multi_reader.sv
// Directed bench for ad2s1210_multi_reader: an SPI responder model answers requests with
// per-channel words; beats, SAMPLE pulses and handshake timing are logged and compared.
`timescale 1ns/1ps
module tb_ad2s1210_multi_reader;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int TW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    read_mode = 2'd0;
    logic [7:0]    sample_length = 8'd4;
    logic [7:0]    sample_delay = 8'd2;
    logic [TW-1:0] timeout = '0;
    logic [31:0]   spi_data_in = '0;
    logic          spi_data_valid = 1'b0;
    logic          spi_transfer_valid;
    logic          spi_transfer_ready = 1'b1;
    logic [31:0]   spi_transfer_data;
    logic [2:0]    spi_transfer_dest;
    logic [1:0]    mode;
    logic          sample;
    logic          busy;
    logic [N-1:0]  fault_flags;
    logic          timeout_error;
    logic          data_out_valid;
    logic          data_out_ready = 1'b1;
    logic [31:0]   data_out_data;
    logic [3:0]    data_out_dest;
    logic [7:0]    data_out_user;
    logic          data_out_last;

    ad2s1210_multi_reader #(.N_CHANNELS(N), .DATA_WIDTH(DW), .TIMEOUT_WIDTH(TW)) dut (
        .clock(clock), .reset(reset), .start(start), .read_mode(read_mode),
        .sample_length(sample_length), .sample_delay(sample_delay), .timeout(timeout),
        .spi_data_in(spi_data_in), .spi_data_valid(spi_data_valid),
        .spi_transfer_valid(spi_transfer_valid), .spi_transfer_ready(spi_transfer_ready),
        .spi_transfer_data(spi_transfer_data), .spi_transfer_dest(spi_transfer_dest),
        .mode(mode), .sample(sample), .busy(busy), .fault_flags(fault_flags),
        .timeout_error(timeout_error), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_data(data_out_data),
        .data_out_dest(data_out_dest), .data_out_user(data_out_user),
        .data_out_last(data_out_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dest;
        logic [7:0]  user;
        logic        last;
        logic [1:0]  mode;
        int          cyc;
    } beat_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SPI responder: strobes the channel's word rsp_lat cycles after the accepting edge
    logic        rsp_en = 1'b1;
    int          rsp_lat = 3;
    logic [31:0] rsp_word [0:N-1];
    int          rsp_ch;
    initial begin
        forever begin
            @(negedge clock);
            if (reset && rsp_en && spi_transfer_valid && spi_transfer_ready) begin
                rsp_ch = int'(spi_transfer_dest);
                @(posedge clock);
                repeat (rsp_lat) @(posedge clock);
                #1;
                spi_data_in    = (rsp_ch < N) ? rsp_word[rsp_ch] : 32'hDEAD_DEAD;
                spi_data_valid = 1'b1;
                @(posedge clock);
                #1;
                spi_data_valid = 1'b0;
                spi_data_in    = '0;
            end
        end
    end

    int    cyc = 0;
    beat_t beats[$];
    int    acc_cyc[$];
    int    req_rise[$];
    int    vrise[$];
    int    pulses, low_run, last_pulse, te_cyc;
    int    stall_cycles, stall_changes, stall_reqs;
    logic  prev_req, prev_valid, prev_te, prev_stalled;
    beat_t cur, snap;
    logic [1:0] mode_at_start;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            low_run = 0; prev_req = 0; prev_valid = 0; prev_te = 0; prev_stalled = 0;
        end else begin
            if (!sample) low_run++;
            else if (low_run > 0) begin
                pulses++; last_pulse = low_run; low_run = 0;
            end
            if (spi_transfer_valid && !prev_req) req_rise.push_back(cyc);
            if (spi_transfer_valid && spi_transfer_ready) acc_cyc.push_back(cyc);
            if (data_out_valid && !prev_valid) vrise.push_back(cyc);
            if (timeout_error && !prev_te) te_cyc = cyc;
            cur = '{data_out_data, data_out_dest, data_out_user, data_out_last, mode, cyc};
            if (data_out_valid && data_out_ready) beats.push_back(cur);
            if (data_out_valid && !data_out_ready) begin
                stall_cycles++;
                if (prev_stalled && (cur.data != snap.data || cur.dest != snap.dest ||
                                     cur.user != snap.user || cur.last != snap.last))
                    stall_changes++;
                if (spi_transfer_valid) stall_reqs++;
                snap = cur;
                prev_stalled = 1;
            end else begin
                prev_stalled = 0;
            end
            prev_req = spi_transfer_valid; prev_valid = data_out_valid; prev_te = timeout_error;
        end
    end

    task automatic clear_log();
        beats.delete(); acc_cyc.delete(); req_rise.delete(); vrise.delete();
        pulses = 0; last_pulse = 0; te_cyc = -1;
        stall_cycles = 0; stall_changes = 0; stall_reqs = 0;
    endtask

    task automatic run_frame(input logic [1:0] rm);
        int n;
        clear_log();
        @(posedge clock); #1;
        read_mode = rm;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        mode_at_start = mode;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("frame_done_busy", busy, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_beat(input int idx, input logic [31:0] data, input logic [3:0] dest,
                            input logic [7:0] user, input logic last, input logic [1:0] md);
        if (idx < beats.size()) begin
            chk($sformatf("beat%0d_data", idx), beats[idx].data, data);
            chk($sformatf("beat%0d_dest", idx), beats[idx].dest, dest);
            chk($sformatf("beat%0d_user", idx), beats[idx].user, user);
            chk($sformatf("beat%0d_last", idx), beats[idx].last, last);
            chk($sformatf("beat%0d_mode", idx), beats[idx].mode, md);
        end else begin
            chk($sformatf("beat%0d_present", idx), beats.size(), idx + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) @(negedge clock);
        chk("rst_sample", sample, 1'b1);
        chk("rst_mode", mode, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_faults", fault_flags, '0);
        chk("rst_timeout_err", timeout_error, 1'b0);
        chk("rst_spi_valid", spi_transfer_valid, 1'b0);
        chk("rst_spi_dest", spi_transfer_dest, 3'd0);
        chk("rst_out_valid", data_out_valid, 1'b0);
        chk("rst_out_fields", {data_out_data, data_out_dest, data_out_user, data_out_last}, '0);
        @(posedge clock); #1;
        reset = 1'b1;

        // position frame, sample_length 4, delay 2, SPI latency 3
        sample_length = 8'd4; sample_delay = 8'd2; rsp_lat = 3;
        rsp_word[0] = 32'h1234_5600; rsp_word[1] = 32'h1234_5600;
        run_frame(2'd0);
        chk("t1_beats", beats.size(), 2);
        chk("t1_pulses", pulses, 1);
        chk("t1_pulse_len", last_pulse, 4);
        chk("t1_mode_start", mode_at_start, 2'b00);
        chk_beat(0, 32'h0000_1234, 4'd0, 8'h00, 1'b0, 2'b00);
        chk_beat(1, 32'h0000_1234, 4'd2, 8'h00, 1'b1, 2'b00);
        // accept edge is acc_cyc+1; beat should become valid rsp_lat+1 edges later
        chk("t1_latency", vrise[0] - (acc_cyc[0] + 1), rsp_lat + 1);
        chk("t1_faults", fault_flags, 2'b00);

        // velocity frame, sample_length 0 behaves as 1
        sample_length = 8'd0; sample_delay = 8'd0; rsp_lat = 1;
        rsp_word[0] = 32'hFFF0_0000; rsp_word[1] = 32'hFFF0_0000;
        run_frame(2'd1);
        chk("t2_beats", beats.size(), 2);
        chk("t2_pulse_len", last_pulse, 1);
        chk("t2_mode_start", mode_at_start, 2'b10);
        chk_beat(0, 32'hFFFF_FFF0, 4'd1, 8'h00, 1'b0, 2'b10);
        chk_beat(1, 32'hFFFF_FFF0, 4'd3, 8'h00, 1'b1, 2'b10);

        // both passes: position then velocity, one SAMPLE pulse, switch gap
        sample_length = 8'd3; sample_delay = 8'd3; rsp_lat = 2;
        rsp_word[0] = 32'h8001_2300; rsp_word[1] = 32'h7FFE_0000;
        run_frame(2'd2);
        chk("t3_beats", beats.size(), 4);
        chk("t3_pulses", pulses, 1);
        chk("t3_pulse_len", last_pulse, 3);
        chk_beat(0, 32'h0000_8001, 4'd0, 8'h00, 1'b0, 2'b00);
        chk_beat(1, 32'h0000_7FFE, 4'd2, 8'h00, 1'b0, 2'b00);
        chk_beat(2, 32'hFFFF_8001, 4'd1, 8'h00, 1'b0, 2'b10);
        chk_beat(3, 32'h0000_7FFE, 4'd3, 8'h00, 1'b1, 2'b10);
        // handshake edge beat+1, then delay+1 edges in SWITCH before the request shows
        if (beats.size() >= 2) chk("t3_switch_gap", req_rise[2] - beats[1].cyc, 3 + 2);

        // backpressure on beat 1 for 10 extra cycles
        sample_length = 8'd2; sample_delay = 8'd0; rsp_lat = 2;
        rsp_word[0] = 32'hABCD_EF05; rsp_word[1] = 32'h0102_0300;
        fork
            run_frame(2'd0);
            begin
                int n;
                n = 0;
                data_out_ready = 1'b0;
                while (!data_out_valid && n < 500) begin
                    @(negedge clock);
                    n++;
                end
                repeat (10) @(negedge clock);
                @(posedge clock); #1;
                data_out_ready = 1'b1;
            end
        join
        chk("t4_beats", beats.size(), 2);
        chk("t4_stall_cycles", stall_cycles, 11);
        chk("t4_stall_changes", stall_changes, 0);
        chk("t4_stall_spi_reqs", stall_reqs, 0);
        chk_beat(0, 32'h0000_ABCD, 4'd0, 8'h05, 1'b0, 2'b00);
        chk_beat(1, 32'h0000_0102, 4'd2, 8'h00, 1'b1, 2'b00);
        chk("t4_faults", fault_flags, 2'b01);

        // timeout with no SPI completion
        timeout = 16'd50; rsp_en = 1'b0;
        run_frame(2'd0);
        chk("t5_timeout_err", timeout_error, 1'b1);
        chk("t5_beats", beats.size(), 0);
        chk("t5_sample", sample, 1'b1);
        // 50 WAIT cycles after the accepting edge
        chk("t5_timeout_cycle", te_cyc - (acc_cyc[0] + 1), 50);
        rsp_en = 1'b1; rsp_lat = 4;
        rsp_word[0] = 32'h0055_0000; rsp_word[1] = 32'h00AA_0000;
        run_frame(2'd0);
        chk("t5b_beats", beats.size(), 2);
        chk_beat(1, 32'h0000_00AA, 4'd2, 8'h00, 1'b1, 2'b00);
        chk("t5b_timeout_sticky", timeout_error, 1'b1);
        timeout = '0;

        // fault byte on channel 1
        rsp_word[0] = 32'h1111_1100; rsp_word[1] = 32'h2222_2240;
        run_frame(2'd0);
        chk_beat(0, 32'h0000_1111, 4'd0, 8'h00, 1'b0, 2'b00);
        chk_beat(1, 32'h0000_2222, 4'd2, 8'h40, 1'b1, 2'b00);
        chk("t6_faults", fault_flags, 2'b10);

        // reset while waiting on the SPI completion of a velocity frame
        begin
            int n;
            clear_log();
            rsp_en = 1'b0;
            @(posedge clock); #1;
            read_mode = 2'd1;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            n = 0;
            while (acc_cyc.size() == 0 && n < 500) begin
                @(negedge clock);
                n++;
            end
            repeat (3) @(negedge clock);
            chk("t7_pre_busy", busy, 1'b1);
            #2;
            reset = 1'b0;
            #1;
            chk("t7_rst_sample", sample, 1'b1);
            chk("t7_rst_mode", mode, 2'b00);
            chk("t7_rst_busy", busy, 1'b0);
            chk("t7_rst_timeout_err", timeout_error, 1'b0);
            chk("t7_rst_faults", fault_flags, '0);
            chk("t7_rst_spi_valid", spi_transfer_valid, 1'b0);
            chk("t7_rst_out", {data_out_valid, data_out_data, data_out_dest, data_out_user, data_out_last}, '0);
            repeat (2) @(posedge clock);
            #1;
            reset = 1'b1;
            rsp_en = 1'b1;
        end
        rsp_word[0] = 32'h0F0F_0000; rsp_word[1] = 32'hF0F0_0000;
        run_frame(2'd0);
        chk("t7_recover_beats", beats.size(), 2);
        chk_beat(1, 32'h0000_F0F0, 4'd2, 8'h00, 1'b1, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ad2s1210_multi_reader.md
Name: ad2s1210_multi_reader

Overview:
Parametrised resolver-to-digital read sequencer for N AD2S1210 devices sharing one SAMPLE line and one SPI master. Per frame it pulses SAMPLE and reads each device in turn over the SPI transfer stream. It can read position, velocity, or both (position pass then velocity pass) and emits one tagged result beat per channel per pass. It handles output backpressure, per-channel fault capture and SPI completion timeout.

Parameters:
N_CHANNELS, 2, number of resolver devices (1..8); channel index drives spi_transfer.dest
DATA_WIDTH, 16, resolver resolution in bits (10..16); result is the top DATA_WIDTH bits of the 24-bit SPI payload
TIMEOUT_WIDTH, 16, width of the timeout counter and timeout port

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  frame request, sampled in IDLE only
read_mode  in  2  0=position, 1=velocity, 2=both, 3=reserved (treated as position)
sample_length  in  8  SAMPLE low time in cycles; 0 treated as 1
sample_delay  in  8  settle cycles after SAMPLE rise and after a mode switch
timeout  in  TIMEOUT_WIDTH  max cycles waiting spi_data_valid; 0 disables
spi_data_in  in  32  SPI receive word: [31:8] payload, [7:0] fault register
spi_data_valid  in  1  one-cycle strobe, spi_data_in valid
spi_transfer  axi_stream master  -  SPI request: data=0, dest=channel index
mode  out  2  AD2S1210 A1:A0: 2'b00 position, 2'b10 velocity
sample  out  1  SAMPLE pin, active low
busy  out  1  high from start acceptance until return to IDLE
fault_flags  out  N_CHANNELS  bit n set if channel n fault byte nonzero in current frame
timeout_error  out  1  sticky; cleared only by reset
data_out  axi_stream master  -  32-bit result; dest={channel,type}; user=fault byte; tlast on last beat of frame

Behaviour:
- Reset (async, active-low): sample=1, mode=0, busy=0, fault_flags=0, timeout_error=0, spi_transfer.valid=0/data=0/dest=0, data_out valid/data/dest/user/tlast=0, all counters 0, state IDLE. Effective mid-frame at any state; no partial beat is emitted.
- States: IDLE, SAMPLE, SETTLE, REQUEST, WAIT, OUTPUT, SWITCH.
- IDLE: start=1 -> latch read_mode, clear fault_flags, channel=0, busy=1, mode=00 (velocity-only: 10) -> SAMPLE next cycle. start while busy ignored.
- SAMPLE: sample=0 for exactly max(sample_length,1) cycles, then sample=1, -> SETTLE.
- SETTLE: wait sample_delay cycles (0 = pass through in one cycle) -> REQUEST.
- REQUEST: spi_transfer.valid=1, dest=channel; hold until valid&ready; valid drops next cycle -> WAIT; timeout counter cleared.
- WAIT: on spi_data_valid capture word -> OUTPUT. If timeout!=0 and counter reaches timeout: timeout_error=1, sample=1, busy=0 -> IDLE; no beat for that channel. spi_data_valid outside WAIT ignored.
- OUTPUT: data_out.valid=1; data = top DATA_WIDTH payload bits, zero-extended (position) or sign-extended (velocity) to 32; dest[0]=type (0 pos, 1 vel), dest[3:1]=channel; user=fault byte; fault_flags[channel] |= (fault byte!=0). Hold all fields stable until ready. On handshake: channel<N_CHANNELS-1 -> channel+1, REQUEST; last channel and mode=both and position pass -> SWITCH; else busy=0 -> IDLE.
- tlast=1 on last channel of the final pass only.
- SWITCH: mode=10, channel=0, wait sample_delay cycles -> REQUEST (no new SAMPLE pulse).
- Latency, position, N=2, delay=0, ready always 1, SPI completes k cycles after request: first beat valid k+1 cycles after request accept.

Test Plan:
- N=2, mode=0, sample_length=4, delay=2, spi_data_in=32'h1234_5600 -> sample low 4 cycles; beats data=32'h0000_1234 dest=0 then dest=2, tlast on second; mode stays 00.
- mode=1, payload 24'hFFF0_00 (top16=16'hFFF0) -> data=32'hFFFF_FFF0, dest[0]=1, mode=10 from frame start.
- mode=2, N=2 -> 4 beats order (ch0 pos, ch1 pos, ch0 vel, ch1 vel); mode switches 00->10 after beat 2 with sample_delay gap; one SAMPLE pulse; tlast only on beat 4.
- data_out.ready low 10 cycles during beat 1 -> data/dest/user stable, no SPI request issued until handshake.
- timeout=50, no spi_data_valid -> timeout_error=1 at cycle 50 of WAIT, busy=0, no beat; next start runs a normal frame, timeout_error stays 1.
- ch1 fault byte 8'h40 -> user=8'h40 on ch1 beat, fault_flags=2'b10; reset asserted in WAIT -> all outputs at reset values immediately.
